// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath widths, ALU control and writeback-select
// encodings, the ID/EX register layout, and the WB-to-ID write-through helper.
package core_pkg;

   localparam int XLEN = 32;
   localparam int RA_W = 5;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b0001;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SRA = 4'b1101;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0111;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_IMM = 2'd3;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [RA_W-1:0] rd;
      logic [RA_W-1:0] rs1;
      logic [RA_W-1:0] rs2;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [3:0]      alu_ctrl;
      logic            a_sel;
      logic            b_sel;
      logic            reg_wen;
      logic            mem_read;
      logic            mem_write;
      logic [1:0]      wb_sel;
   } id_ex_t;

   // The register file is read in the same cycle WB writes it, so the old value must be bypassed.
   function automatic logic [XLEN-1:0] write_through(
      input logic [RA_W-1:0] rs,
      input logic [XLEN-1:0] rf_data,
      input logic            wb_wen,
      input logic [RA_W-1:0] wb_rd,
      input logic [XLEN-1:0] wb_data
   );
      if (wb_wen && (wb_rd != '0) && (wb_rd == rs)) return wb_data;
      return rf_data;
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// EX-stage operand forwarding for one source register: MEM beats WB beats the stored value.
module fwd_mux
   import core_pkg::*;
(
   input  logic [RA_W-1:0] rs,
   input  logic [XLEN-1:0] stored,
   input  logic [RA_W-1:0] mem_rd,
   input  logic            mem_reg_wen,
   input  logic [XLEN-1:0] mem_result,
   input  logic [RA_W-1:0] wb_rd,
   input  logic            wb_reg_wen,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] fwd
);

   always_comb begin
      fwd = stored;
      if (mem_reg_wen && (mem_rd != '0) && (mem_rd == rs)) begin
         fwd = mem_result;
      end else if (wb_reg_wen && (wb_rd != '0) && (wb_rd == rs)) begin
         fwd = wb_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields with WB write-through, detects
// load-use hazards, inserts bubbles, and forwards MEM/WB results into the ALU operands.
module id_ex_stage
   import core_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic [RA_W-1:0] id_rd,
   input  logic            id_rs1_used,
   input  logic            id_rs2_used,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [3:0]      id_alu_ctrl,
   input  logic            id_a_sel,
   input  logic            id_b_sel,
   input  logic            id_reg_wen,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic [1:0]      id_wb_sel,
   input  logic [RA_W-1:0] mem_rd,
   input  logic            mem_reg_wen,
   input  logic [XLEN-1:0] mem_result,
   input  logic [RA_W-1:0] wb_rd,
   input  logic            wb_reg_wen,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            stall_id,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_imm,
   output logic [RA_W-1:0] ex_rd,
   output logic [XLEN-1:0] ex_alu_a,
   output logic [XLEN-1:0] ex_alu_b,
   output logic [3:0]      ex_alu_ctrl,
   output logic [XLEN-1:0] ex_store_data,
   output logic            ex_reg_wen,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic [1:0]      ex_wb_sel
);

   id_ex_t          ex_q;
   id_ex_t          ex_d;
   logic            hazard;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   // Stall handshake: stall_id high means ID must hold its instruction (PC and IF/ID frozen)
   // and a bubble enters EX this edge; the held instruction is captured on the next edge.
   always_comb begin
      hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
               ((id_rs1_used && (ex_q.rd == id_rs1)) || (id_rs2_used && (ex_q.rd == id_rs2)));
      stall_id = hazard && id_valid && !flush;
   end

   always_comb begin
      ex_d = '0;
      if (!flush && !stall_id) begin
         ex_d.valid     = id_valid;
         ex_d.pc        = id_pc;
         ex_d.imm       = id_imm;
         ex_d.rd        = id_rd;
         ex_d.rs1       = id_rs1;
         ex_d.rs2       = id_rs2;
         ex_d.rs1_data  = write_through(id_rs1, id_rs1_data, wb_reg_wen, wb_rd, wb_data);
         ex_d.rs2_data  = write_through(id_rs2, id_rs2_data, wb_reg_wen, wb_rd, wb_data);
         ex_d.alu_ctrl  = id_alu_ctrl;
         ex_d.a_sel     = id_a_sel;
         ex_d.b_sel     = id_b_sel;
         ex_d.reg_wen   = id_reg_wen && id_valid;
         ex_d.mem_read  = id_mem_read && id_valid;
         ex_d.mem_write = id_mem_write && id_valid;
         ex_d.wb_sel    = id_wb_sel;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) ex_q <= '0;
      else       ex_q <= ex_d;
   end

   fwd_mux u_fwd_rs1 (
      .rs          (ex_q.rs1),
      .stored      (ex_q.rs1_data),
      .mem_rd      (mem_rd),
      .mem_reg_wen (mem_reg_wen),
      .mem_result  (mem_result),
      .wb_rd       (wb_rd),
      .wb_reg_wen  (wb_reg_wen),
      .wb_data     (wb_data),
      .fwd         (fwd_rs1)
   );

   fwd_mux u_fwd_rs2 (
      .rs          (ex_q.rs2),
      .stored      (ex_q.rs2_data),
      .mem_rd      (mem_rd),
      .mem_reg_wen (mem_reg_wen),
      .mem_result  (mem_result),
      .wb_rd       (wb_rd),
      .wb_reg_wen  (wb_reg_wen),
      .wb_data     (wb_data),
      .fwd         (fwd_rs2)
   );

   always_comb begin
      ex_valid      = ex_q.valid;
      ex_pc         = ex_q.pc;
      ex_imm        = ex_q.imm;
      ex_rd         = ex_q.rd;
      ex_alu_a      = ex_q.a_sel ? ex_q.pc : fwd_rs1;
      ex_alu_b      = ex_q.b_sel ? ex_q.imm : fwd_rs2;
      ex_alu_ctrl   = ex_q.alu_ctrl;
      ex_store_data = fwd_rs2;
      ex_reg_wen    = ex_q.reg_wen;
      ex_mem_read   = ex_q.mem_read;
      ex_mem_write  = ex_q.mem_write;
      ex_wb_sel     = ex_q.wb_sel;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the five-stage RV32I core. It sits directly upstream of the EX-stage ALU and produces the ALU operands and the 4-bit ALU control.
- It captures decoded ID fields and applies WB-to-ID write-through at capture.
- In EX it forwards from MEM and WB, detects load-use hazards, stalls ID, and inserts bubbles. Branch-mispredict flushes are accepted.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses.
- id_rs1_used, id_rs2_used  in  1  instruction actually reads rs1/rs2.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_alu_ctrl  in  4  {funct7[5],funct3}-style ALU control.
- id_a_sel  in  1  0=rs1, 1=PC.
- id_b_sel  in  1  0=rs2, 1=imm.
- id_reg_wen, id_mem_read, id_mem_write  in  1  control bits.
- id_wb_sel  in  2  writeback source.
- mem_rd  in  RA_W; mem_reg_wen  in  1; mem_result  in  XLEN.
- wb_rd  in  RA_W; wb_reg_wen  in  1; wb_data  in  XLEN.
- flush  in  1  kill the instruction entering EX.
- stall_id  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_imm  out  XLEN.
- ex_rd  out  RA_W.
- ex_alu_a, ex_alu_b  out  XLEN  ALU operands after forwarding and muxing.
- ex_alu_ctrl  out  4.
- ex_store_data  out  XLEN  forwarded rs2.
- ex_reg_wen, ex_mem_read, ex_mem_write  out  1.
- ex_wb_sel  out  2.

Behaviour:
- Reset (async, active-high): every registered field clears to 0, including ex_valid. ex_alu_ctrl=4'b0000 (add). ex_alu_a/ex_alu_b then evaluate to 0 while no forwarding source is active.
- Hazard: hazard = ex_valid & ex_mem_read & (ex_rd!=0) & ((id_rs1_used & ex_rd==id_rs1) | (id_rs2_used & ex_rd==id_rs2)).
- stall_id = hazard & id_valid & ~flush. It is combinational, in the same cycle as the hazard.
- Register update priority at posedge clock: reset > flush > stall_id > capture.
- Flush or stall_id loads a bubble: ex_valid, ex_reg_wen, ex_mem_read and ex_mem_write=0; all other fields 0.
- Capture: all id_* fields are registered. ex_valid=id_valid. Control bits are ANDed with id_valid.
- Write-through at capture: if wb_reg_wen & wb_rd!=0 & wb_rd==id_rs1, the stored rs1 value is wb_data instead of id_rs1_data. rs2 is handled identically.
- EX forwarding (combinational from registered state), applied separately to rs1 and rs2:
  - MEM forward if mem_reg_wen & mem_rd!=0 & mem_rd==ex_rsN.
  - Else WB forward if wb_reg_wen & wb_rd!=0 & wb_rd==ex_rsN.
  - Else the stored value.
  - MEM has priority over WB. x0 is never forwarded.
- Operand selection: ex_alu_a = a_sel ? ex_pc : fwd_rs1. ex_alu_b = b_sel ? ex_imm : fwd_rs2. ex_store_data = fwd_rs2 always.
- Latency: one cycle from ID to EX registers. Operands are valid in the same cycle the forwarding sources are.
- Stall duration: exactly one bubble per load-use pair. The next cycle the load has moved to MEM, so hazard deasserts and the MEM path is not used for load data (the load result reaches EX via the WB path).
- Input contract: mem_reg_wen and wb_reg_wen are pre-gated by their stage's valid bit.
- Reset mid-stall: registers clear immediately. stall_id drops because ex_valid=0.

Decomposition:
- Shared package core_pkg holds:
  - ALU control encodings: ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLL=4'b0001, ALU_SRL=4'b0101, ALU_SRA=4'b1101, ALU_XOR=4'b0100, ALU_OR=4'b0110, ALU_AND=4'b0111.
  - Writeback-select constants.
  - XLEN and RA_W.
- One natural sub-module: fwd_mux. It takes rsN, the stored data, and the MEM/WB tuples, and returns the forwarded value. It is instantiated twice.

Test Plan:
- Capture path: id_valid=1, rs1 data 0x10, rs2 data 0x20, a_sel=0, b_sel=0, ctrl 0000, no forwarding -> next cycle ex_alu_a=0x10, ex_alu_b=0x20, ex_alu_ctrl=0000, ex_valid=1.
- Forward priority: ex_rs1=5; mem_rd=5 with mem_result=0xAA and wb_rd=5 with wb_data=0xBB, both wen=1 -> ex_alu_a=0xAA. Drop mem_reg_wen -> ex_alu_a=0xBB. Repeat with rd=0 -> stored value.
- Load-use: EX holds lw x7 (mem_read=1, rd=7); ID holds add reading rs2=x7 with rs2_used=1 -> stall_id=1. Next cycle ex_valid=0 and mem_write=0. The following cycle the add is captured and stall_id=0. Repeat with rs2_used=0 -> stall_id=0.
- Write-through: wb_reg_wen=1, wb_rd=3, wb_data=0x1234 while ID reads rs1=3 with stale data 0x0 -> after capture (no forwarding active) ex_alu_a=0x1234.
- Flush wins: hazard and flush asserted together -> stall_id=0 and a bubble is loaded. Immediate mux: b_sel=1, imm=0xFFFFFFFC -> ex_alu_b=0xFFFFFFFC while ex_store_data still carries the forwarded rs2.
- Async reset asserted mid-stall between clock edges -> all ex_* outputs 0 immediately and stall_id=0.
